// File: rtl/change_pkg.sv
// Shared types and coin values for the change dispenser.
// Coin enum order doubles as the greedy priority (largest coin first).
package change_pkg;
    typedef enum logic [2:0] {IDLE, SELECT, EJECT, RELEASE, DONE} state_e;
    typedef enum logic [1:0] {PEN, FA, HFA, NONE} coin_e;

    localparam int PEN_VAL = 8;
    localparam int FA_VAL  = 2;
    localparam int HFA_VAL = 1;
    localparam int INV_W   = 4;

    function automatic int coin_val(coin_e c);
        case (c)
            PEN:     return PEN_VAL;
            FA:      return FA_VAL;
            HFA:     return HFA_VAL;
            default: return 0;
        endcase
    endfunction
endpackage

// File: rtl/change_dispenser_if.sv
// Pay request from the vending FSM plus the ejector handshake and status.
// master = environment (FSM + ejector), slave = change_dispenser.
interface change_dispenser_if #(parameter int AMT_W = 5);
    logic             start;
    logic [AMT_W-1:0] change_amt;
    logic             eject_ack;
    logic             refill;
    logic             eject_pen;
    logic             eject_fa;
    logic             eject_hfa;
    logic             busy;
    logic             done;
    logic             short_chg;

    modport master (
        output start, change_amt, eject_ack, refill,
        input  eject_pen, eject_fa, eject_hfa, busy, done, short_chg
    );
    modport slave (
        input  start, change_amt, eject_ack, refill,
        output eject_pen, eject_fa, eject_hfa, busy, done, short_chg
    );
endinterface

// File: rtl/change_dispenser_coin_select.sv
// Combinational greedy picker: largest available coin whose value fits in rem.
module coin_select
    import change_pkg::*;
#(
    parameter int AMT_W = 5
) (
    input  logic [AMT_W-1:0] rem,
    input  logic             pen_av,
    input  logic             fa_av,
    input  logic             hfa_av,
    output coin_e            coin,
    output logic [AMT_W-1:0] value
);
    always_comb begin
        coin = NONE;
        if (pen_av && int'(rem) >= PEN_VAL)     coin = PEN;
        else if (fa_av && int'(rem) >= FA_VAL)   coin = FA;
        else if (hfa_av && int'(rem) >= HFA_VAL) coin = HFA;
        value = AMT_W'(coin_val(coin));
    end
endmodule

// File: rtl/change_dispenser.sv
// Pays owed change one coin at a time via a four-phase ejector handshake.
// Define CHANGE_INV_EN for per-denomination inventory counters and short_chg.
module change_dispenser
    import change_pkg::*;
#(
    parameter int AMT_W   = 5,
    parameter int INV_MAX = 15
) (
    input  logic              CLK,
    input  logic              RES,
    change_dispenser_if.slave bus
);
    state_e           state_q, state_d;
    coin_e            coin_q, coin_d, sel_coin;
    logic [AMT_W-1:0] rem_q, rem_d, val_q, val_d, sel_val;
    logic             short_q, short_d, busy_q, busy_d, done_q, done_d;
    logic [2:0]       ej_q, ej_d;
    logic             pen_av, fa_av, hfa_av, take;

    coin_select #(.AMT_W(AMT_W)) u_sel (
        .rem   (rem_q),
        .pen_av(pen_av),
        .fa_av (fa_av),
        .hfa_av(hfa_av),
        .coin  (sel_coin),
        .value (sel_val)
    );

`ifdef CHANGE_INV_EN
    logic [2:0][INV_W-1:0] inv_q, inv_d;

    // Refill beats a same-cycle decrement.
    always_comb begin
        inv_d = inv_q;
        if (bus.refill) begin
            inv_d = {3{INV_W'(INV_MAX)}};
        end else if (take) begin
            case (coin_q)
                PEN:     inv_d[0] = inv_q[0] - INV_W'(1);
                FA:      inv_d[1] = inv_q[1] - INV_W'(1);
                HFA:     inv_d[2] = inv_q[2] - INV_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) inv_q <= {3{INV_W'(INV_MAX)}};
        else     inv_q <= inv_d;
    end

    assign pen_av        = (inv_q[0] != '0);
    assign fa_av         = (inv_q[1] != '0);
    assign hfa_av        = (inv_q[2] != '0);
    assign bus.short_chg = short_q;
`else
    localparam int unused_inv_max = INV_MAX;
    logic unused_cfg;
    assign unused_cfg    = ^{bus.refill, short_q};
    assign pen_av        = 1'b1;
    assign fa_av         = 1'b1;
    assign hfa_av        = 1'b1;
    assign bus.short_chg = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        val_d   = val_q;
        coin_d  = coin_q;
        short_d = short_q;
        take    = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                rem_d   = bus.change_amt;
                short_d = 1'b0;
                state_d = (bus.change_amt == '0) ? DONE : SELECT;
            end
            SELECT: if (sel_coin == NONE) begin
                short_d = 1'b1;
                state_d = DONE;
            end else begin
                coin_d  = sel_coin;
                val_d   = sel_val;
                state_d = EJECT;
            end
            EJECT: if (bus.eject_ack) begin
                take    = 1'b1;
                rem_d   = rem_q - val_q;
                state_d = RELEASE;
            end
            RELEASE: if (!bus.eject_ack) state_d = (rem_q == '0) ? DONE : SELECT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        ej_d   = 3'b000;
        if (state_d == EJECT) begin
            case (coin_d)
                PEN:     ej_d = 3'b100;
                FA:      ej_d = 3'b010;
                HFA:     ej_d = 3'b001;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q <= IDLE;
            rem_q   <= '0;
            val_q   <= '0;
            coin_q  <= NONE;
            short_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ej_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            val_q   <= val_d;
            coin_q  <= coin_d;
            short_q <= short_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ej_q    <= ej_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.eject_pen = ej_q[2];
    assign bus.eject_fa  = ej_q[1];
    assign bus.eject_hfa = ej_q[0];
endmodule

// File: tb/tb_change_dispenser.sv
// Table-driven bench for change_dispenser; ejector acks after a per-vector delay.
// Coin order is packed 2 bits per coin (pen=1, fa=2, hfa=3), oldest coin in the MSBs.
module tb_change_dispenser;
    localparam int AMT_W = 5;
`ifdef CHANGE_INV_EN
    localparam int INV = 1;
`else
    localparam int INV = 15;
`endif

    logic CLK, RES;
    int   errors = 0;
    int   checks = 0;

    change_dispenser_if #(.AMT_W(AMT_W)) bus ();
    change_dispenser #(.AMT_W(AMT_W), .INV_MAX(INV)) dut (.CLK(CLK), .RES(RES), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // amt, ack delay, start-inject cycle, refill before start, refill cycle,
    // expected coin sequence, cycles from start cycle to done (inclusive), short_chg
    typedef struct {
        int amt; int d; int inj; int pre_rf; int rf_at;
        int seq; int cyc; int shrt;
    } vec_t;
    vec_t vt[$];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int outs();
        return {bus.busy, bus.done, bus.eject_pen, bus.eject_fa, bus.eject_hfa, bus.short_chg};
    endfunction

    task automatic run_txn(input int amt, input int d, input int inj, input int pre_rf,
                           input int rf_at, output int seq, output int cyc,
                           output int bad, output int shrt);
        int hi;
        logic prev, fin;
        logic [2:0] ej;
        seq = 0; cyc = 1; bad = 0; hi = 0; prev = 0; shrt = 0; fin = 0;
        if (pre_rf != 0) begin
            bus.refill = 1'b1;
            @(negedge CLK);
            bus.refill = 1'b0;
        end
        bus.start = 1'b1;
        bus.change_amt = AMT_W'(amt);
        while (!fin) begin
            @(negedge CLK);
            cyc++;
            bus.start = (cyc == inj);
            if (cyc == inj) bus.change_amt = AMT_W'(3);
            bus.refill = (cyc == rf_at);
            ej = {bus.eject_pen, bus.eject_fa, bus.eject_hfa};
            if ($countones(ej) > 1) bad++;
            if (!bus.busy) bad++;
            if (ej != 3'b000 && !prev) seq = (seq << 2) | (ej[2] ? 1 : (ej[1] ? 2 : 3));
            prev = (ej != 3'b000);
            if (ej != 3'b000) begin
                hi++;
                if (hi > d) bus.eject_ack = 1'b1;
            end else begin
                hi = 0;
                bus.eject_ack = 1'b0;
            end
            if (bus.done) begin
                shrt = int'(bus.short_chg);
                fin = 1'b1;
            end else if (cyc > 300) begin
                bad++;
                fin = 1'b1;
            end
        end
        bus.start = 1'b0; bus.refill = 1'b0; bus.eject_ack = 1'b0;
        @(negedge CLK);
        if (bus.busy || bus.done) bad++;
    endtask

    initial begin
        int seq, cyc, bad, shrt, n, k, cnt;
        logic prev;
        logic [2:0] ej;

`ifdef CHANGE_INV_EN
        vt.push_back('{13, 0, 0, 0, 0, 'h1B, 12, 1});
        vt.push_back('{ 4, 0, 0, 1, 0, 'hB,   9, 1});
        vt.push_back('{ 2, 0, 0, 1, 3, 2,     5, 0});
        vt.push_back('{ 2, 0, 0, 0, 0, 2,     5, 0});
        vt.push_back('{ 2, 0, 0, 0, 0, 3,     6, 1});
        vt.push_back('{ 0, 0, 0, 0, 0, 0,     2, 0});
`else
        vt.push_back('{13, 0, 0, 0, 0, 'h6B,   14, 0});
        vt.push_back('{ 0, 0, 0, 0, 0, 0,       2, 0});
        vt.push_back('{10, 5, 0, 0, 0, 6,      18, 0});
        vt.push_back('{31, 0, 0, 0, 0, 'h15AB, 23, 0});
        vt.push_back('{ 1, 0, 0, 0, 0, 3,       5, 0});
        vt.push_back('{ 9, 2, 0, 0, 0, 7,      12, 0});
        vt.push_back('{10, 2, 3, 0, 0, 6,      12, 0});
        vt.push_back('{13, 0, 0, 1, 3, 'h6B,   14, 0});
`endif

        bus.start = 1'b0; bus.change_amt = '0; bus.eject_ack = 1'b0; bus.refill = 1'b0;
        RES = 1'b1;
        repeat (3) @(negedge CLK);
        check("reset_outs", outs(), 0);
        RES = 1'b0;
        @(negedge CLK);
        check("idle_outs", outs(), 0);

        foreach (vt[i]) begin
            run_txn(vt[i].amt, vt[i].d, vt[i].inj, vt[i].pre_rf, vt[i].rf_at, seq, cyc, bad, shrt);
            check($sformatf("v%0d_seq", i), seq, vt[i].seq);
            check($sformatf("v%0d_cycles", i), cyc, vt[i].cyc);
            check($sformatf("v%0d_short", i), shrt, vt[i].shrt);
            check($sformatf("v%0d_protocol", i), bad, 0);
        end

        // Reset during the second coin's EJECT abandons the transaction.
        bus.start = 1'b1; bus.change_amt = AMT_W'(13);
        n = 0; k = 0; prev = 1'b0;
        while (n < 2 && k < 100) begin
            @(negedge CLK);
            k++;
            bus.start = 1'b0;
            ej = {bus.eject_pen, bus.eject_fa, bus.eject_hfa};
            if (ej != 3'b000 && !prev) begin
                n++;
                if (n == 1) bus.eject_ack = 1'b1;
            end
            if (ej == 3'b000) bus.eject_ack = 1'b0;
            prev = (ej != 3'b000);
        end
        check("res_second_coin", n, 2);
        check("res_ejecting", outs() & 6'b001110 ? 1 : 0, 1);
        RES = 1'b1;
        @(negedge CLK);
        RES = 1'b0;
        check("res_outs", outs(), 0);
        cnt = 0;
        repeat (20) begin
            @(negedge CLK);
            if (bus.done || bus.busy) cnt++;
        end
        check("res_no_done", cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
